// File: rtl/mcu_subsys_bus_fabric.sv
// Routes one picorv32-native master to NUM_SLAVES targets by base/mask decode, with timeout and error response.
// Optional error logging (err_addr, err_count) when MCU_SUBSYS_BUS_ERR_LOG_EN is defined.
module mcu_subsys_bus_fabric #(
  parameter int                         NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {32'h8000_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {32'h8000_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                         TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       m_mem_valid,
  output logic                       m_mem_ready,
  input  logic [31:0]                m_mem_addr,
  input  logic [31:0]                m_mem_wdata,
  input  logic [3:0]                 m_mem_wstrb,
  output logic [31:0]                m_mem_rdata,
  output logic                       m_bus_err,
  output logic [NUM_SLAVES-1:0]      s_mem_valid,
  input  logic [NUM_SLAVES-1:0]      s_mem_ready,
  output logic [31:0]                s_mem_addr,
  output logic [31:0]                s_mem_wdata,
  output logic [3:0]                 s_mem_wstrb,
  input  logic [NUM_SLAVES*32-1:0]   s_mem_rdata
`ifdef MCU_SUBSYS_BUS_ERR_LOG_EN
  ,
  output logic [31:0]                err_addr,
  output logic [15:0]                err_count
`endif
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RESP = 2'd2} state_t;

  state_t                 state_r, next_state_s;
  logic [SEL_W-1:0]       sel_r;
  logic [15:0]            cnt_r;
  logic [NUM_SLAVES-1:0]  match_s;
  logic                   hit_s;
  logic [SEL_W-1:0]       hit_idx_s;
  logic                   sel_ready_s;
  logic [31:0]            sel_rdata_s;
  logic                   timeout_s;

  // Address decode; walking downwards lets the lowest matching index win.
  always_comb begin
    match_s   = '0;
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      match_s[i] = ((m_mem_addr & SLAVE_MASK[32*i +: 32]) == (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]));
      hit_idx_s  = match_s[i] ? SEL_W'(i) : hit_idx_s;
      hit_s      = hit_s | match_s[i];
    end
  end

  assign sel_ready_s = s_mem_ready[sel_r];
  assign sel_rdata_s = s_mem_rdata[32*sel_r +: 32];
  assign timeout_s   = (cnt_r == TO_LAST);

  // Next-state logic; ready beats a simultaneous timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (m_mem_valid) begin
          next_state_s = hit_s ? ACTIVE : RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (sel_ready_s || timeout_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = ACTIVE;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath and registered outputs; m_mem_ready/m_bus_err are set on entry to RESP.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r       <= '0;
      cnt_r       <= 16'd0;
      s_mem_valid <= '0;
      s_mem_addr  <= 32'd0;
      s_mem_wdata <= 32'd0;
      s_mem_wstrb <= 4'd0;
      m_mem_rdata <= 32'd0;
      m_mem_ready <= 1'b0;
      m_bus_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m_mem_valid) begin
            s_mem_addr  <= m_mem_addr;
            s_mem_wdata <= m_mem_wdata;
            s_mem_wstrb <= m_mem_wstrb;
            if (hit_s) begin
              sel_r       <= hit_idx_s;
              s_mem_valid <= SEL_ONE << hit_idx_s;
            end else begin
              m_mem_rdata <= ERR_RDATA;
              m_mem_ready <= 1'b1;
              m_bus_err   <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          cnt_r <= cnt_r + 16'd1;
          if (sel_ready_s) begin
            s_mem_valid <= '0;
            m_mem_rdata <= sel_rdata_s;
            m_mem_ready <= 1'b1;
            m_bus_err   <= 1'b0;
          end else if (timeout_s) begin
            s_mem_valid <= '0;
            m_mem_rdata <= ERR_RDATA;
            m_mem_ready <= 1'b1;
            m_bus_err   <= 1'b1;
          end
        end
        RESP: begin
          cnt_r       <= 16'd0;
          m_mem_ready <= 1'b0;
          m_bus_err   <= 1'b0;
        end
        default: begin
          s_mem_valid <= '0;
          m_mem_ready <= 1'b0;
          m_bus_err   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MCU_SUBSYS_BUS_ERR_LOG_EN
  logic err_event_s;
  logic [31:0] err_event_addr_s;

  assign err_event_s      = ((state_r == IDLE) && m_mem_valid && !hit_s) ||
                            ((state_r == ACTIVE) && !sel_ready_s && timeout_s);
  assign err_event_addr_s = (state_r == IDLE) ? m_mem_addr : s_mem_addr;

  // Error log: last failing address and a saturating error count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr  <= 32'd0;
      err_count <= 16'd0;
    end else if (err_event_s) begin
      err_addr  <= err_event_addr_s;
      err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mcu_subsys_bus_fabric.md
Name: mcu_subsys_bus_fabric

Overview:
Parametrised successor to the fixed ROM/SRAM/peripheral host bridge. It routes one picorv32-native master bus to NUM_SLAVES slave ports using per-slave base/mask address decode. It adds a per-transaction timeout and an error response for unmapped or hung accesses. It sits between u_picorv32 and all memory/peripheral targets in mcu_subsys_top.

Parameters:
NUM_SLAVES, 3, number of slave ports (1..8).
SLAVE_BASE, {32'h8000_0000, 32'h0001_0000, 32'h0000_0000}, packed NUM_SLAVES*32 base addresses; slave i uses bits [32*i+:32].
SLAVE_MASK, {32'h8000_0000, 32'hFFFF_0000, 32'hFFFF_0000}, packed NUM_SLAVES*32 decode masks.
TIMEOUT_CYCLES, 255, maximum ACTIVE cycles before abort (1..65535).
ERR_RDATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
sys_clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
m_mem_valid  input  1  master request valid
m_mem_ready  output  1  master response strobe, one cycle
m_mem_addr  input  32  master address
m_mem_wdata  input  32  master write data
m_mem_wstrb  input  4  write strobes; 0 means read
m_mem_rdata  output  32  registered response data
m_bus_err  output  1  one-cycle pulse, coincident with m_mem_ready on an error response
s_mem_valid  output  NUM_SLAVES  one-hot slave request
s_mem_ready  input  NUM_SLAVES  slave ready
s_mem_addr  output  32  registered address, shared by all slaves
s_mem_wdata  output  32  registered write data, shared
s_mem_wstrb  output  4  registered strobes, shared
s_mem_rdata  input  NUM_SLAVES*32  slave read data, packed

Behaviour:
- Clock sys_clk; reset rst_n is asynchronous and active-low.
- Reset values: every output is 0; state is IDLE; timeout counter is 0. Asserting reset mid-transaction clears all outputs immediately. No response is issued for the aborted access.
- Decode: slave i matches when (m_mem_addr & MASK_i) == (BASE_i & MASK_i). If several slaves match, the lowest index wins.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE, when m_mem_valid=1:
  - Register addr, wdata and wstrb.
  - If a slave matches: register sel, then go to ACTIVE.
  - If no slave matches: load ERR_RDATA, set err_flag, then go to RESP.
- ACTIVE:
  - s_mem_valid[sel]=1; all other s_mem_valid bits are 0; the counter increments each cycle.
  - When s_mem_ready[sel]=1: capture s_mem_rdata[sel], drop s_mem_valid the next cycle, go to RESP.
  - Else when counter == TIMEOUT_CYCLES-1: drop s_mem_valid, load ERR_RDATA, set err_flag, go to RESP.
  - If ready arrives in the same cycle as the timeout, ready wins and the response is normal.
- RESP: m_mem_ready=1 for exactly one cycle, m_bus_err=err_flag, then clear the counter and err_flag and return to IDLE.
- The fabric does not decode in the RESP cycle. The next request is accepted in IDLE one cycle later.
- Latency:
  - Slave ready in its first ACTIVE cycle gives m_mem_ready 3 cycles after m_mem_valid is sampled (IDLE → ACTIVE → RESP).
  - Unmapped access gives m_mem_ready 2 cycles after m_mem_valid is sampled.
- s_mem_ready on a non-selected slave, or in any state other than ACTIVE, is ignored.
- m_mem_valid dropping mid-transaction (illegal for the master) does not abort the transaction; the response is still issued.
- On writes, m_mem_rdata holds the captured slave rdata; the master ignores it.
- The counter is 16-bit. The comparison uses TIMEOUT_CYCLES-1, so TIMEOUT_CYCLES=1 aborts after one ACTIVE cycle.

Optional Feature:
MCU_SUBSYS_BUS_ERR_LOG_EN:
- Defined: adds output err_addr[31:0] and output err_count[15:0].
  - err_addr is loaded with the registered address on each error response.
  - err_count increments on each error response and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Read 0x0000_0010, slave0 ready on its first ACTIVE cycle with rdata 0x1234_5678 → s_mem_valid=3'b001 for 1 cycle; m_mem_ready 3 cycles after request; m_mem_rdata=0x1234_5678; m_bus_err=0.
- Write 0x0001_0004, wdata 0xA5A5_A5A5, wstrb 4'b0011, slave1 ready after 4 cycles → s_mem_wdata/s_mem_wstrb match; s_mem_valid=3'b010 for 4 cycles; single m_mem_ready pulse.
- Read 0x4000_0000 (unmapped) → no s_mem_valid; m_mem_ready 2 cycles after request; rdata=0xDEAD_BEEF; m_bus_err=1; with macro, err_addr=0x4000_0000 and err_count=1.
- TIMEOUT_CYCLES=8, read 0x8000_0000, slave2 never ready → s_mem_valid[2] high exactly 8 cycles; then m_mem_ready with rdata=0xDEAD_BEEF and m_bus_err=1; a following read to slave0 completes normally.
- Slave2 ready in the same cycle as the timeout (TIMEOUT_CYCLES=8, ready in ACTIVE cycle 8), rdata 0x0000_0042 → normal response, rdata=0x0000_0042, m_bus_err=0.
- rst_n low during ACTIVE → s_mem_valid and m_mem_ready are 0 immediately; after release the FSM is in IDLE and the next read completes normally.
